// File: rtl/flux_rr_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hevc_sched_pkg
//  Brief    : Shared types and helpers for the flux round-robin scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package hevc_sched_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } sched_state_e;

    function automatic int tag_w(input int flux);
        return $clog2(flux);
    endfunction

    // Increment that wraps at the flux count, not at the next power of two.
    function automatic int wrap_inc(input int idx, input int flux);
        return (idx + 1 >= flux) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flux_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : flux_rr_scheduler_if
//  Brief    : FIFO status / strobe / statistics bundle between actor and scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
interface flux_rr_scheduler_if
    import hevc_sched_pkg::*;
#(
    parameter int FLUX      = 2,
    parameter int STAT_W    = 16,
    parameter int TAG_WIDTH = tag_w(FLUX)
);
    logic [FLUX-1:0]        empty_a;
    logic [FLUX-1:0]        empty_b;
    logic [FLUX-1:0]        full_o;
    logic [FLUX-1:0]        read_a;
    logic [FLUX-1:0]        read_b;
    logic                   write_o;
    logic [TAG_WIDTH-1:0]   tag;
    logic                   stat_clr;
    logic [FLUX*STAT_W-1:0] stat_cnt;

    modport slave (
        input  empty_a, empty_b, full_o, stat_clr,
        output read_a, read_b, write_o, tag, stat_cnt
    );

    modport master (
        output empty_a, empty_b, full_o, stat_clr,
        input  read_a, read_b, write_o, tag, stat_cnt
    );

endinterface
`default_nettype wire

// File: rtl/flux_rr_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Brief    : Rotating priority encoder; first unmasked request from i_start.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int FLUX      = 2,
    parameter int TAG_WIDTH = 1
) (
    input  wire logic [FLUX-1:0]      i_req,
    input  wire logic [TAG_WIDTH-1:0] i_start,
    input  wire logic [FLUX-1:0]      i_mask,
    output logic                      o_found,
    output logic [TAG_WIDTH-1:0]      o_idx
);
    logic [FLUX-1:0] w_eff;

    assign w_eff = i_req & ~i_mask;

    // Scan from the far end back so the candidate nearest i_start wins.
    always_comb begin
        int c;
        c       = 0;
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = FLUX - 1; k >= 0; k--) begin
            c = int'(i_start) + k;
            if (c >= FLUX) c = c - FLUX;
            if (w_eff[c]) begin
                o_found = 1'b1;
                o_idx   = TAG_WIDTH'(c);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/flux_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : flux_rr_scheduler
//  Brief    : Round-robin + burst-hold sequencer for a shared multi-flux actor.
//             Optional per-flux fire counters built when SCHED_STATS_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module flux_rr_scheduler
    import hevc_sched_pkg::*;
#(
    parameter int FLUX      = 2,
    parameter int BURST_LEN = 4,
    parameter int TAG_WIDTH = tag_w(FLUX),
    parameter int STAT_W    = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    flux_rr_scheduler_if.slave bus
);
    localparam int         C_CNT_W   = $clog2(BURST_LEN + 1);
    localparam logic [0:0] C_ST_IDLE = IDLE;
    localparam logic [0:0] C_ST_HOLD = HOLD;

    logic [0:0]           r_state;
    logic [TAG_WIDTH-1:0] r_ptr;
    logic [TAG_WIDTH-1:0] r_cur;
    logic [C_CNT_W-1:0]   r_cnt;

    logic [FLUX-1:0]      w_elig;
    logic [FLUX-1:0]      w_mask;
    logic [FLUX-1:0]      w_fire_vec;
    logic [TAG_WIDTH-1:0] w_start;
    logic [TAG_WIDTH-1:0] w_cur_next;
    logic [TAG_WIDTH-1:0] w_pick_idx;
    logic [TAG_WIDTH-1:0] w_pick_next;
    logic [TAG_WIDTH-1:0] w_fire_idx;
    logic                 w_hold;
    logic                 w_pick_found;
    logic                 w_cont;
    logic                 w_fire;

    assign w_elig      = ~bus.empty_a & ~bus.empty_b & ~bus.full_o;
    assign w_hold      = (r_state == C_ST_HOLD);
    assign w_cur_next  = TAG_WIDTH'(wrap_inc(int'(r_cur), FLUX));
    assign w_pick_next = TAG_WIDTH'(wrap_inc(int'(w_pick_idx), FLUX));

    // While holding, a stalled owner is released in the same cycle: arbitration
    // restarts just past it with the owner masked, so no bubble is inserted.
    assign w_start = w_hold ? w_cur_next : r_ptr;
    assign w_mask  = w_hold ? (FLUX'(1) << r_cur) : '0;

    rr_pick #(
        .FLUX      (FLUX),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_rr_pick (
        .i_req   (w_elig),
        .i_start (w_start),
        .i_mask  (w_mask),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    assign w_cont     = w_hold & w_elig[r_cur];
    assign w_fire     = (w_cont | w_pick_found) & ~rst;
    assign w_fire_idx = w_cont ? r_cur : w_pick_idx;
    assign w_fire_vec = w_fire ? (FLUX'(1) << w_fire_idx) : '0;

    assign bus.read_a  = w_fire_vec;
    assign bus.read_b  = w_fire_vec;
    assign bus.write_o = w_fire;
    assign bus.tag     = w_fire ? w_fire_idx : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
            r_ptr   <= '0;
            r_cur   <= '0;
            r_cnt   <= '0;
        end else if (w_cont) begin
            r_cnt <= r_cnt + C_CNT_W'(1);
            if (int'(r_cnt) + 1 >= BURST_LEN) begin
                r_ptr   <= w_cur_next;
                r_state <= C_ST_IDLE;
            end
        end else if (w_pick_found) begin
            if (BURST_LEN == 1) begin
                r_ptr   <= w_pick_next;
                r_state <= C_ST_IDLE;
            end else begin
                r_cur   <= w_pick_idx;
                r_cnt   <= C_CNT_W'(1);
                r_state <= C_ST_HOLD;
            end
        end else if (w_hold) begin
            r_ptr   <= w_cur_next;
            r_state <= C_ST_IDLE;
        end
    end

`ifdef SCHED_STATS_EN
    generate
        for (genvar gi = 0; gi < FLUX; gi++) begin : g_stat
            logic [STAT_W-1:0] r_stat;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_stat <= '0;
                end else if (bus.stat_clr) begin
                    r_stat <= '0;
                end else if (w_fire_vec[gi] && (r_stat != '1)) begin
                    r_stat <= r_stat + STAT_W'(1);
                end
            end

            assign bus.stat_cnt[gi*STAT_W +: STAT_W] = r_stat;
        end
    endgenerate
`else
    logic w_unused_stat_clr;
    assign w_unused_stat_clr = bus.stat_clr;
    assign bus.stat_cnt      = '0;
`endif

endmodule
`default_nettype wire
